// File: rtl/ifm_buf_ring_sel_if.sv
// Bank-ring arbiter bus: writer/reader event pulses in,
// bank indices, allows, counters, per-bank state and error pulses out.
interface ifm_buf_ring_sel_if #(
  parameter int NUM_BUF = 2
);
  localparam int IDX_W = $clog2(NUM_BUF);
  localparam int CNT_W = $clog2(NUM_BUF + 1);

  logic                 flush;
  logic                 sys_wr_start;
  logic                 sys_wr_end;
  logic                 mod_rd_start;
  logic                 mod_rd_end;
  logic [IDX_W-1:0]     wr_buf_idx;
  logic [IDX_W-1:0]     rd_buf_idx;
  logic                 wr_allow;
  logic                 rd_allow;
  logic [CNT_W-1:0]     ready_cnt;
  logic [CNT_W-1:0]     free_cnt;
  logic [2*NUM_BUF-1:0] bank_state;
  logic                 wr_err;
  logic                 rd_err;

  modport master (
    output flush, sys_wr_start, sys_wr_end,
    output mod_rd_start, mod_rd_end,
    input  wr_buf_idx, rd_buf_idx, wr_allow, rd_allow,
    input  ready_cnt, free_cnt, bank_state,
    input  wr_err, rd_err
  );

  modport slave (
    input  flush, sys_wr_start, sys_wr_end,
    input  mod_rd_start, mod_rd_end,
    output wr_buf_idx, rd_buf_idx, wr_allow, rd_allow,
    output ready_cnt, free_cnt, bank_state,
    output wr_err, rd_err
  );
endinterface

// File: rtl/ifm_buf_ring_sel.sv
// N-bank IFM ring arbiter between system writer and compute reader.
// Ports: clock, rst_n (async low), bus (slave: events in, status out).
module ifm_buf_ring_sel #(
  parameter int NUM_BUF = 2,
  localparam int IDX_W = $clog2(NUM_BUF),
  localparam int CNT_W = $clog2(NUM_BUF + 1)
) (
  input logic           clock,
  input logic           rst_n,
  ifm_buf_ring_sel_if.slave bus
);

  localparam logic [1:0] FREE    = 2'b00;
  localparam logic [1:0] WRITING = 2'b01;
  localparam logic [1:0] READY   = 2'b10;
  localparam logic [1:0] READING = 2'b11;

  logic [2*NUM_BUF-1:0] bank_q;
  logic [2*NUM_BUF-1:0] bank_d;
  logic [IDX_W-1:0]     wr_ptr;
  logic [IDX_W-1:0]     rd_ptr;
  logic                 wr_busy;
  logic                 rd_busy;
  logic                 wr_err_q;
  logic                 rd_err_q;
  logic [1:0]           wr_bank;
  logic [1:0]           rd_bank;
  logic                 wr_ok;
  logic                 rd_ok;
  logic                 wr_go;
  logic                 wr_done;
  logic                 rd_go;
  logic                 rd_done;
  logic                 wr_bad;
  logic                 rd_bad;
  logic [CNT_W-1:0]     ready_n;
  logic [CNT_W-1:0]     free_n;

  function automatic logic [IDX_W-1:0] nxt(
    input logic [IDX_W-1:0] p
  );
    return (p == IDX_W'(NUM_BUF - 1)) ? '0
         : p + IDX_W'(1);
  endfunction

  // Mux by compare so non-power-of-2 rings never
  // index past the last bank.
  always_comb begin
    wr_bank = FREE;
    rd_bank = FREE;
    for (int i = 0; i < NUM_BUF; i++) begin
      if (wr_ptr == IDX_W'(i))
        wr_bank = bank_q[2*i +: 2];
      if (rd_ptr == IDX_W'(i))
        rd_bank = bank_q[2*i +: 2];
    end
  end

  assign wr_ok   = !wr_busy && (wr_bank == FREE);
  assign rd_ok   = !rd_busy && (rd_bank == READY);
  assign wr_go   = bus.sys_wr_start && wr_ok;
  assign wr_done = bus.sys_wr_end && wr_busy;
  assign rd_go   = bus.mod_rd_start && rd_ok;
  assign rd_done = bus.mod_rd_end && rd_busy;
  assign wr_bad  = (bus.sys_wr_start && !wr_ok)
                || (bus.sys_wr_end && !wr_busy);
  assign rd_bad  = (bus.mod_rd_start && !rd_ok)
                || (bus.mod_rd_end && !rd_busy);

  // Accepted events always target distinct banks,
  // so the four updates never collide.
  always_comb begin
    bank_d = bank_q;
    for (int i = 0; i < NUM_BUF; i++) begin
      if (wr_go && wr_ptr == IDX_W'(i))
        bank_d[2*i +: 2] = WRITING;
      if (wr_done && wr_ptr == IDX_W'(i))
        bank_d[2*i +: 2] = READY;
      if (rd_go && rd_ptr == IDX_W'(i))
        bank_d[2*i +: 2] = READING;
      if (rd_done && rd_ptr == IDX_W'(i))
        bank_d[2*i +: 2] = FREE;
    end
  end

  always_comb begin
    ready_n = '0;
    free_n  = '0;
    for (int i = 0; i < NUM_BUF; i++) begin
      if (bank_q[2*i +: 2] == READY)
        ready_n = ready_n + CNT_W'(1);
      if (bank_q[2*i +: 2] == FREE)
        free_n = free_n + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      bank_q   <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      wr_busy  <= 1'b0;
      rd_busy  <= 1'b0;
      wr_err_q <= 1'b0;
      rd_err_q <= 1'b0;
    end else if (bus.flush) begin
      bank_q   <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      wr_busy  <= 1'b0;
      rd_busy  <= 1'b0;
      wr_err_q <= 1'b0;
      rd_err_q <= 1'b0;
    end else begin
      bank_q   <= bank_d;
      wr_err_q <= wr_bad;
      rd_err_q <= rd_bad;
      if (wr_go) begin
        wr_busy <= 1'b1;
      end else if (wr_done) begin
        wr_busy <= 1'b0;
        wr_ptr  <= nxt(wr_ptr);
      end
      if (rd_go) begin
        rd_busy <= 1'b1;
      end else if (rd_done) begin
        rd_busy <= 1'b0;
        rd_ptr  <= nxt(rd_ptr);
      end
    end
  end

  assign bus.wr_buf_idx = wr_ptr;
  assign bus.rd_buf_idx = rd_ptr;
  assign bus.wr_allow   = wr_ok;
  assign bus.rd_allow   = rd_ok;
  assign bus.ready_cnt  = ready_n;
  assign bus.free_cnt   = free_n;
  assign bus.bank_state = bank_q;
  assign bus.wr_err     = wr_err_q;
  assign bus.rd_err     = rd_err_q;

endmodule
